alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Control block for the clock/alarm datapath. Routes the MIN/HR set buttons to the time or alarm registers as one-cycle pulses.
//  Selects which value the display shows. Detects an alarm match and sequences ringing, snooze, timeout and cancel.
//  Runs on the divided system clock, alongside the time counter, alarm register and 7-seg decoder blocks.
// PARAMETERS
//  RING_TIMEOUT_S  60   ticks of ringing before auto-stop (1..255)
//  SNOOZE_S        300  ticks of snooze before re-ring (1..1023)
// PORTS
//  clk            in   1  system clock (divided clock domain)
//  reset          in   1  synchronous, active-high reset
//  tick_1hz       in   1  one-cycle enable, once per second
//  set_clock      in   1  level: time-set mode
//  set_alarm      in   1  level: alarm-set mode
//  min_btn        in   1  level: minute-advance button (already debounced)
//  hr_btn         in   1  level: hour-advance button (already debounced)
//  alarm_off      in   1  level: stop alarm
//  snooze         in   1  level: snooze request
//  t_hour_tens/t_hour_unit/t_min_tens/t_min_unit/t_seg_tens/t_seg_unit  in  4 each  current time, BCD
//  a_hour_tens/a_hour_unit/a_min_tens/a_min_unit                        in  4 each  alarm time, BCD
//  time_min_inc   out  1  pulse: advance time minutes
//  time_hr_inc    out  1  pulse: advance time hours
//  alarm_min_inc  out  1  pulse: advance alarm minutes
//  alarm_hr_inc   out  1  pulse: advance alarm hours
//  change_display out  1  1 = display shows alarm value, 0 = display shows time
//  alarm_out      out  1  buzzer drive
//  state          out  2  FSM state, for debug
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, counters 0, edge-detect history 0.
//  Button routing:
//   - Rising edge of min_btn/hr_btn (registered history) produces a one-clk pulse on the cycle after the edge.
//   - set_clock=1: pulses go to time_* (set_clock wins if both modes are high).
//   - else set_alarm=1: pulses go to alarm_*.
//   - else: pulses are dropped.
//   - A button held across a mode change produces no new pulse.
//  change_display = registered (set_alarm & ~set_clock); 1-clk latency.
//  Match = (t_hour,t_min == a_hour,a_min) & t_seg==00 & tick_1hz & ~set_clock & ~set_alarm.
//  FSM encoding: IDLE=0, RINGING=1, SNOOZE=2.
//   - IDLE -> RINGING on match. Load ring_cnt=0 and set alarm_out=1.
//   - RINGING:
//     - Each tick: alarm_out toggles and ring_cnt increments.
//     - ring_cnt==RING_TIMEOUT_S-1 at a tick -> IDLE.
//     - alarm_off -> IDLE.
//     - Rising edge of snooze -> SNOOZE. Load snz_cnt=SNOOZE_S.
//     - Matches are ignored while RINGING.
//   - SNOOZE:
//     - alarm_out=0. snz_cnt decrements on each tick.
//     - Tick with snz_cnt==1 -> RINGING (ring_cnt=0, alarm_out=1).
//     - alarm_off -> IDLE.
//   - set_alarm asserted in RINGING or SNOOZE -> IDLE (cancel).
//   - Same-cycle priority: reset > alarm_off = set_alarm cancel > timeout > snooze > tick update.
//   - alarm_out is 0 in every state other than RINGING.
//  Counter widths: ring_cnt 8 b, snz_cnt 10 b; no wrap is reachable.
//  Reset mid-ring or mid-snooze -> IDLE next clk; alarm_out=0.
// CONFIGURATION
//  SNOOZE_FEATURE_EN defined:
//   - SNOOZE state and snz_cnt exist, as described above.
//  Not defined:
//   - snooze is ignored; the FSM is IDLE/RINGING only.
//   - The state encoding is unchanged; state never reads 2.
// STRUCTURE
//  clock_alarm_defs.vh holds:
//   - state localparams IDLE/RINGING/SNOOZE;
//   - BCD width 4;
//   - default timeout constants.
//  Sub-module btn_edge_pulse (rising-edge detector: 1-bit history, 1-clk pulse).
//   - Instantiated for min_btn, hr_btn and snooze.
// TESTING
//  1. set_clock=1, press min_btn 3 clk -> exactly one time_min_inc pulse 1 clk after edge; alarm_*=0.
//  2. set_clock=set_alarm=1, press hr_btn -> time_hr_inc pulse only; change_display=0.
//  3. Alarm 07:30, time 07:29:59 -> tick -> 07:30:00 -> alarm_out=1, state=1; toggles each tick.
//  4. RINGING, no input, RING_TIMEOUT_S=3 -> state=0 after 3rd tick; alarm_out=0.
//  5. SNOOZE_FEATURE_EN, SNOOZE_S=2:
//     - snooze edge in RINGING -> state=2, alarm_out=0.
//     - After 2 ticks -> state=1, alarm_out=1.
//  6. alarm_off and snooze edge in the same cycle -> state=0.
//     Separate case: reset during SNOOZE -> state=0 and all outputs 0 next clk.

Source files
------------

// File: rtl/alarm_sequencer_pkg.sv
// rtl/alarm_sequencer_pkg.sv - shared state encoding, BCD width and default timeouts
package alarm_sequencer_pkg;

  localparam int BCD_W = 4;

  localparam int DEF_RING_TIMEOUT_S = 60;
  localparam int DEF_SNOOZE_S       = 300;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

endpackage

// File: rtl/alarm_sequencer_if.sv
// rtl/alarm_sequencer_if.sv - user controls, BCD time/alarm values and control outputs
interface alarm_sequencer_if;
  import alarm_sequencer_pkg::*;

  logic             tick_1hz;
  logic             set_clock;
  logic             set_alarm;
  logic             min_btn;
  logic             hr_btn;
  logic             alarm_off;
  logic             snooze;
  logic [BCD_W-1:0] t_hour_tens;
  logic [BCD_W-1:0] t_hour_unit;
  logic [BCD_W-1:0] t_min_tens;
  logic [BCD_W-1:0] t_min_unit;
  logic [BCD_W-1:0] t_seg_tens;
  logic [BCD_W-1:0] t_seg_unit;
  logic [BCD_W-1:0] a_hour_tens;
  logic [BCD_W-1:0] a_hour_unit;
  logic [BCD_W-1:0] a_min_tens;
  logic [BCD_W-1:0] a_min_unit;
  logic             time_min_inc;
  logic             time_hr_inc;
  logic             alarm_min_inc;
  logic             alarm_hr_inc;
  logic             change_display;
  logic             alarm_out;
  logic [1:0]       state;

  modport master (
    output tick_1hz, set_clock, set_alarm, min_btn, hr_btn, alarm_off, snooze,
    output t_hour_tens, t_hour_unit, t_min_tens, t_min_unit, t_seg_tens, t_seg_unit,
    output a_hour_tens, a_hour_unit, a_min_tens, a_min_unit,
    input  time_min_inc, time_hr_inc, alarm_min_inc, alarm_hr_inc,
    input  change_display, alarm_out, state
  );

  modport slave (
    input  tick_1hz, set_clock, set_alarm, min_btn, hr_btn, alarm_off, snooze,
    input  t_hour_tens, t_hour_unit, t_min_tens, t_min_unit, t_seg_tens, t_seg_unit,
    input  a_hour_tens, a_hour_unit, a_min_tens, a_min_unit,
    output time_min_inc, time_hr_inc, alarm_min_inc, alarm_hr_inc,
    output change_display, alarm_out, state
  );

endinterface

// File: rtl/alarm_sequencer_btn_edge_pulse.sv
// rtl/alarm_sequencer_btn_edge_pulse.sv - rising-edge detector with 1-bit history
module btn_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic hist_q;

  // Remember last cycle's level so a held button yields a single pulse.
  always_ff @(posedge clk) begin
    if (reset) hist_q <= 1'b0;
    else       hist_q <= btn_i;
  end

  // High only in the cycle where the level is 1 and was 0 the cycle before.
  always_comb pulse_o = btn_i & ~hist_q;

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - button routing, display select and ring/snooze FSM; SNOOZE_FEATURE_EN enables snooze
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int SNOOZE_S       = DEF_SNOOZE_S
) (
  input logic              clk,
  input logic              reset,
  alarm_sequencer_if.slave bus
);

  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

  logic min_pulse;
  logic hr_pulse;
  logic snooze_pulse;

  btn_edge_pulse u_min_edge    (.clk(clk), .reset(reset), .btn_i(bus.min_btn), .pulse_o(min_pulse));
  btn_edge_pulse u_hr_edge     (.clk(clk), .reset(reset), .btn_i(bus.hr_btn),  .pulse_o(hr_pulse));
  btn_edge_pulse u_snooze_edge (.clk(clk), .reset(reset), .btn_i(bus.snooze),  .pulse_o(snooze_pulse));

  logic time_min_inc_q, time_hr_inc_q, alarm_min_inc_q, alarm_hr_inc_q;
  logic change_display_q;

  // Route button pulses by mode; set_clock takes precedence over set_alarm.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_min_inc_q   <= 1'b0;
      time_hr_inc_q    <= 1'b0;
      alarm_min_inc_q  <= 1'b0;
      alarm_hr_inc_q   <= 1'b0;
      change_display_q <= 1'b0;
    end else begin
      time_min_inc_q   <= min_pulse & bus.set_clock;
      time_hr_inc_q    <= hr_pulse  & bus.set_clock;
      alarm_min_inc_q  <= min_pulse & ~bus.set_clock & bus.set_alarm;
      alarm_hr_inc_q   <= hr_pulse  & ~bus.set_clock & bus.set_alarm;
      change_display_q <= bus.set_alarm & ~bus.set_clock;
    end
  end

  logic match;
  logic cancel;

  // Alarm fires only on the tick at hh:mm:00 and never while either set mode is active.
  always_comb begin
    match = (bus.t_hour_tens == bus.a_hour_tens) && (bus.t_hour_unit == bus.a_hour_unit) &&
            (bus.t_min_tens  == bus.a_min_tens)  && (bus.t_min_unit  == bus.a_min_unit)  &&
            (bus.t_seg_tens  == '0) && (bus.t_seg_unit == '0) &&
            bus.tick_1hz && !bus.set_clock && !bus.set_alarm;
    cancel = bus.alarm_off | bus.set_alarm;
  end

  state_e     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       buzz_q, buzz_d;
`ifdef SNOOZE_FEATURE_EN
  logic [9:0] snz_cnt_q, snz_cnt_d;
`endif

  // FSM state and counters register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      buzz_q     <= 1'b0;
`ifdef SNOOZE_FEATURE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      buzz_q     <= buzz_d;
`ifdef SNOOZE_FEATURE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  // Next-state: cancel beats timeout, timeout beats snooze, snooze beats the tick update.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    buzz_d     = buzz_q;
`ifdef SNOOZE_FEATURE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        buzz_d = 1'b0;
        if (match) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
          buzz_d     = 1'b1;
        end
      end
      RINGING: begin
        if (cancel) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
        end else if (bus.tick_1hz && ring_cnt_q == RING_LAST) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
`ifdef SNOOZE_FEATURE_EN
        end else if (snooze_pulse) begin
          state_d   = SNOOZE;
          snz_cnt_d = 10'(SNOOZE_S);
          buzz_d    = 1'b0;
`endif
        end else if (bus.tick_1hz) begin
          buzz_d     = ~buzz_q;
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
`ifdef SNOOZE_FEATURE_EN
      SNOOZE: begin
        buzz_d = 1'b0;
        if (cancel) begin
          state_d = IDLE;
        end else if (bus.tick_1hz) begin
          if (snz_cnt_q == 10'd1) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            buzz_d     = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q - 10'd1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        buzz_d  = 1'b0;
      end
    endcase
  end

  // Outputs: buzzer is forced low outside RINGING; state exported for debug.
  always_comb begin
    bus.alarm_out      = (state_q == RINGING) & buzz_q;
    bus.state          = state_q;
    bus.time_min_inc   = time_min_inc_q;
    bus.time_hr_inc    = time_hr_inc_q;
    bus.alarm_min_inc  = alarm_min_inc_q;
    bus.alarm_hr_inc   = alarm_hr_inc_q;
    bus.change_display = change_display_q;
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed self-checking bench for alarm_sequencer
module tb_alarm_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alarm_sequencer_if bus ();

  alarm_sequencer #(.RING_TIMEOUT_S(3), .SNOOZE_S(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    bus.t_hour_tens = 4'(hh / 10);
    bus.t_hour_unit = 4'(hh % 10);
    bus.t_min_tens  = 4'(mm / 10);
    bus.t_min_unit  = 4'(mm % 10);
    bus.t_seg_tens  = 4'(ss / 10);
    bus.t_seg_unit  = 4'(ss % 10);
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic ring_up(input string tag);
    set_time(7, 30, 0);
    tick();
    set_time(7, 31, 0);
    chk({tag, "_state"}, 32'(bus.state), 32'd1);
    chk({tag, "_buzz"}, 32'(bus.alarm_out), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.tick_1hz = 0; bus.set_clock = 0; bus.set_alarm = 0;
    bus.min_btn = 0; bus.hr_btn = 0; bus.alarm_off = 0; bus.snooze = 0;
    set_time(0, 0, 0);
    bus.a_hour_tens = 4'd0; bus.a_hour_unit = 4'd7;
    bus.a_min_tens  = 4'd3; bus.a_min_unit  = 4'd0;
    step();
    step();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_outs", {26'd0, bus.time_min_inc, bus.time_hr_inc, bus.alarm_min_inc,
                     bus.alarm_hr_inc, bus.change_display, bus.alarm_out}, 32'd0);
    reset = 1'b0;

    // time-set: held min_btn gives one pulse
    bus.set_clock = 1; bus.min_btn = 1;
    step();
    chk("t1_tmin_p", 32'(bus.time_min_inc), 32'd1);
    chk("t1_amin_p", 32'(bus.alarm_min_inc), 32'd0);
    step();
    chk("t1_tmin_hold1", 32'(bus.time_min_inc), 32'd0);
    step();
    chk("t1_tmin_hold2", 32'(bus.time_min_inc), 32'd0);
    bus.min_btn = 0;
    step();

    // both modes: set_clock wins
    bus.set_alarm = 1; bus.hr_btn = 1;
    step();
    chk("t2_thr", 32'(bus.time_hr_inc), 32'd1);
    chk("t2_ahr", 32'(bus.alarm_hr_inc), 32'd0);
    chk("t2_disp", 32'(bus.change_display), 32'd0);
    bus.hr_btn = 0; bus.set_clock = 0;
    step();
    chk("disp_alarm", 32'(bus.change_display), 32'd1);

    // alarm-set routing, then held across mode change
    bus.min_btn = 1;
    step();
    chk("amin_p", 32'(bus.alarm_min_inc), 32'd1);
    chk("amin_t", 32'(bus.time_min_inc), 32'd0);
    bus.set_alarm = 0; bus.set_clock = 1;
    step();
    chk("held_mode", {30'd0, bus.time_min_inc, bus.alarm_min_inc}, 32'd0);
    bus.min_btn = 0; bus.set_clock = 0;
    step();
    chk("disp_time", 32'(bus.change_display), 32'd0);

    // no mode: pulse dropped
    bus.hr_btn = 1;
    step();
    chk("drop", {30'd0, bus.time_hr_inc, bus.alarm_hr_inc}, 32'd0);
    bus.hr_btn = 0;
    step();

    // 07:29:59 tick: no match
    set_time(7, 29, 59);
    tick();
    chk("no_match", 32'(bus.state), 32'd0);
    // match suppressed in set_alarm mode
    set_time(7, 30, 0);
    bus.set_alarm = 1;
    tick();
    chk("match_setmode", 32'(bus.state), 32'd0);
    bus.set_alarm = 0;
    step();

    // match, toggle, timeout after 3 ticks
    ring_up("t3");
    step();
    chk("t3_noclk", 32'(bus.alarm_out), 32'd1);
    tick();
    chk("t4_tk1_buzz", 32'(bus.alarm_out), 32'd0);
    chk("t4_tk1_state", 32'(bus.state), 32'd1);
    tick();
    chk("t4_tk2_buzz", 32'(bus.alarm_out), 32'd1);
    tick();
    chk("t4_tk3_state", 32'(bus.state), 32'd0);
    chk("t4_tk3_buzz", 32'(bus.alarm_out), 32'd0);

    // timeout beats snooze
    ring_up("pri");
    tick();
    tick();
    bus.snooze = 1; bus.tick_1hz = 1;
    step();
    bus.snooze = 0; bus.tick_1hz = 0;
    chk("pri_timeout", 32'(bus.state), 32'd0);
    step();

    // snooze sequence
    ring_up("t5");
    bus.snooze = 1;
    step();
    bus.snooze = 0;
`ifdef SNOOZE_FEATURE_EN
    chk("t5_snz_state", 32'(bus.state), 32'd2);
    chk("t5_snz_buzz", 32'(bus.alarm_out), 32'd0);
    tick();
    chk("t5_tk1", 32'(bus.state), 32'd2);
`else
    chk("t5_ign_state", 32'(bus.state), 32'd1);
    chk("t5_ign_buzz", 32'(bus.alarm_out), 32'd1);
    tick();
    chk("t5_tk1", 32'(bus.state), 32'd1);
`endif
    tick();
    chk("t5_rering_state", 32'(bus.state), 32'd1);
    chk("t5_rering_buzz", 32'(bus.alarm_out), 32'd1);
    bus.alarm_off = 1;
    step();
    bus.alarm_off = 0;
    chk("t5_off", 32'(bus.state), 32'd0);

    // alarm_off and snooze edge together
    ring_up("t6");
    bus.alarm_off = 1; bus.snooze = 1;
    step();
    bus.alarm_off = 0; bus.snooze = 0;
    chk("t6_off_snz", 32'(bus.state), 32'd0);
    chk("t6_off_buzz", 32'(bus.alarm_out), 32'd0);
    step();

    // set_alarm cancels ringing
    ring_up("cx");
    bus.set_alarm = 1;
    step();
    bus.set_alarm = 0;
    chk("cancel_set", 32'(bus.state), 32'd0);
    step();

    // reset while snoozing (or ringing when snooze is absent)
    ring_up("rs");
    bus.snooze = 1;
    step();
    bus.snooze = 0;
    reset = 1;
    step();
    reset = 0;
    chk("rs_state", 32'(bus.state), 32'd0);
    chk("rs_outs", {26'd0, bus.time_min_inc, bus.time_hr_inc, bus.alarm_min_inc,
                    bus.alarm_hr_inc, bus.change_display, bus.alarm_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
